// File: rtl/edge_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_monitor_pkg
// Brief    : Shared FSM state encoding and default parameter values for the
//            edge_monitor measurement block and its synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
package edge_monitor_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : edge_monitor_pkg
`default_nettype wire

// File: rtl/edge_monitor_sync.sv
`default_nettype none
// ============================================================================
// Module   : edge_sync
// Brief    : Multi-flop synchronizer for the asynchronous monitored input,
//            followed by a history flop that turns a 0->1 of the synchronized
//            value into a one-cycle EDGE pulse.
// Revision : 1.0 - initial release
// ============================================================================
module edge_sync
  import edge_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF  // 2 or 3
) (
  input  logic CLK,
  input  logic RN,
  input  logic A,
  output logic EDGE
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // Shift A through the synchronizer chain and remember the last synced value.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], A};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  // Both operands are flop outputs, so the pulse is glitch-free and one cycle wide.
  assign EDGE = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule : edge_sync
`default_nettype wire

// File: rtl/edge_monitor.sv
`default_nettype none
// ============================================================================
// Module   : edge_monitor
// Brief    : Counts rising edges of an asynchronous input over a programmable
//            window of CLK cycles and presents the (saturating) count with a
//            valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module edge_monitor
  import edge_monitor_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  // Window timer width. Defaults to CNT_W. A window of at most 2^CNT_W-1
  // cycles can never hold enough synchronized edges to saturate the counter,
  // so a wider timer is the only way to exercise saturation on narrow counts.
  parameter int TMR_W       = CNT_W
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             A,
  input  logic             START,
  input  logic [TMR_W-1:0] WIN,
  input  logic             RDY,
  output logic [CNT_W-1:0] Y,
  output logic             VLD,
  output logic             BUSY,
  output logic             OVF
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic [CNT_W-1:0]   r_y;
  logic               w_load_y;
  logic               w_edge;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .CLK  (CLK),
    .RN   (RN),
    .A    (A),
    .EDGE (w_edge)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    w_load_y    = 1'b0;
    case (r_state)
      IDLE: begin
        // A zero-length window is meaningless and is dropped.
        if (START && (WIN != '0)) begin
          w_state_nxt = COUNT;
          w_timer_nxt = WIN;
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      COUNT: begin
        w_timer_nxt = r_timer - TMR_W'(1);
        if (w_edge) begin
          if (&r_count) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
        // Timer value 1 marks the last window cycle; its edge is still counted.
        if (r_timer == TMR_W'(1)) begin
          w_state_nxt = DONE;
          w_load_y    = 1'b1;
        end
      end
      DONE: begin
        if (RDY) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Window timer, edge counter, overflow flag and result register.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_timer <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_y     <= '0;
    end else begin
      r_timer <= w_timer_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      if (w_load_y) begin
        r_y <= w_count_nxt;
      end
    end
  end

  assign Y    = r_y;
  assign OVF  = r_ovf;
  assign VLD  = (r_state == DONE);
  assign BUSY = (r_state == COUNT);

endmodule : edge_monitor
`default_nettype wire

// File: tb/tb_edge_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_monitor
// Brief    : Directed self-checking bench for edge_monitor. One instance uses
//            the default 16-bit configuration, a second uses a 4-bit counter
//            with an 8-bit timer for the saturation scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_monitor;

  logic        CLK = 1'b0;
  logic        RN;
  logic        A;
  logic        START;
  logic        RDY;
  logic [15:0] WIN16;
  logic [7:0]  WIN8;

  logic [15:0] Y16;
  logic        VLD16, BUSY16, OVF16;
  logic [3:0]  Y4;
  logic        VLD4, BUSY4, OVF4;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  edge_monitor u_dut16 (
    .CLK   (CLK),
    .RN    (RN),
    .A     (A),
    .START (START),
    .WIN   (WIN16),
    .RDY   (RDY),
    .Y     (Y16),
    .VLD   (VLD16),
    .BUSY  (BUSY16),
    .OVF   (OVF16)
  );

  edge_monitor #(
    .CNT_W       (4),
    .SYNC_STAGES (2),
    .TMR_W       (8)
  ) u_dut4 (
    .CLK   (CLK),
    .RN    (RN),
    .A     (A),
    .START (START),
    .WIN   (WIN8),
    .RDY   (RDY),
    .Y     (Y4),
    .VLD   (VLD4),
    .BUSY  (BUSY4),
    .OVF   (OVF4)
  );

  // Drives one measurement window cycle by cycle. Cycle index c refers to the
  // posedge that follows the negedge on which inputs are driven; START is
  // applied for c==0. A rise of A at c is consumed by the FSM at posedge c+2,
  // so it is counted when 1 <= c+2 <= win. Returns on the negedge after the
  // final window posedge, with the selected instance expected in DONE.
  task automatic run_win(input int win, input bit use4, input logic [255:0] mask,
                         output int busy_cycles);
    busy_cycles = 0;
    if (use4) begin
      WIN8  = 8'(win);
      WIN16 = '0;
    end else begin
      WIN16 = 16'(win);
      WIN8  = '0;
    end
    for (int c = -3; c <= win + 1; c++) begin
      @(negedge CLK);
      if ((use4 ? BUSY4 : BUSY16) === 1'b1) busy_cycles++;
      A     = mask[c+3];
      START = (c == 0);
    end
    START = 1'b0;
    A     = 1'b0;
  endtask

  task automatic test_reset();
    RN = 1'b0; A = 1'b0; START = 1'b0; RDY = 1'b0; WIN16 = '0; WIN8 = '0;
    repeat (3) @(negedge CLK);
    checks++; if (Y16 !== 16'd0)  begin errors++; $display("FAIL reset_y16 got %0d want 0", Y16); end
    checks++; if ({VLD16, BUSY16, OVF16} !== 3'b000)
      begin errors++; $display("FAIL reset_flags16 got %b want 000", {VLD16, BUSY16, OVF16}); end
    checks++; if ({Y4, VLD4, BUSY4, OVF4} !== 7'd0)
      begin errors++; $display("FAIL reset_dut4 got %b want 0000000", {Y4, VLD4, BUSY4, OVF4}); end
    RN = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_basic_count();
    logic [255:0] mask;
    int           bc;
    mask = '0;
    for (int k = 0; k < 5; k++) begin
      mask[10 + 20*k + 3] = 1'b1;
      mask[10 + 20*k + 4] = 1'b1;
    end
    run_win(100, 1'b0, mask, bc);
    checks++; if (bc !== 100)      begin errors++; $display("FAIL basic_busy_cycles got %0d want 100", bc); end
    checks++; if (VLD16 !== 1'b1)  begin errors++; $display("FAIL basic_vld got %b want 1", VLD16); end
    checks++; if (Y16 !== 16'd5)   begin errors++; $display("FAIL basic_y got %0d want 5", Y16); end
    checks++; if (OVF16 !== 1'b0)  begin errors++; $display("FAIL basic_ovf got %b want 0", OVF16); end
  endtask

  // Starts in DONE with Y=5 left by the basic count.
  task automatic test_handshake();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++; if ({VLD16, Y16} !== {1'b1, 16'd5})
        begin errors++; $display("FAIL hs_hold cycle %0d got vld=%b y=%0d want vld=1 y=5", i, VLD16, Y16); end
    end
    WIN16 = 16'd100; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    checks++; if ({BUSY16, VLD16} !== 2'b01)
      begin errors++; $display("FAIL hs_start_in_done got busy=%b vld=%b want busy=0 vld=1", BUSY16, VLD16); end
    RDY = 1'b1;
    @(negedge CLK);
    RDY = 1'b0;
    checks++; if ({BUSY16, VLD16} !== 2'b00)
      begin errors++; $display("FAIL hs_rdy_release got busy=%b vld=%b want 00", BUSY16, VLD16); end
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    checks++; if (BUSY16 !== 1'b1) begin errors++; $display("FAIL hs_restart_busy got %b want 1", BUSY16); end
  endtask

  // Continues the window started by test_handshake and aborts it.
  task automatic test_abort();
    int bad;
    repeat (48) @(negedge CLK);
    #2 RN = 1'b0;
    #1;
    checks++; if (Y16 !== 16'd0)  begin errors++; $display("FAIL abort_y got %0d want 0", Y16); end
    checks++; if ({VLD16, BUSY16, OVF16} !== 3'b000)
      begin errors++; $display("FAIL abort_flags got %b want 000", {VLD16, BUSY16, OVF16}); end
    @(negedge CLK);
    RN = 1'b1;
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge CLK);
      if (VLD16 !== 1'b0 || BUSY16 !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort_no_result got %0d active cycles want 0", bad); end
  endtask

  task automatic test_win_zero();
    int bad;
    WIN16 = '0; WIN8 = '0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (BUSY16 !== 1'b0 || BUSY4 !== 1'b0) bad++;
      @(negedge CLK);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL win_zero_busy got %0d busy cycles want 0", bad); end
  endtask

  task automatic test_boundary();
    logic [255:0] mask;
    int           bc;
    // Edges consumed on window cycle 1 and on cycle WIN.
    mask = '0;
    mask[2] = 1'b1; mask[3] = 1'b1;     // A high c=-1,0
    mask[11] = 1'b1; mask[12] = 1'b1;   // A high c=8,9
    run_win(10, 1'b0, mask, bc);
    checks++; if (bc !== 10)      begin errors++; $display("FAIL bnd_in_busy got %0d want 10", bc); end
    checks++; if ({VLD16, Y16} !== {1'b1, 16'd2})
      begin errors++; $display("FAIL bnd_in_y got vld=%b y=%0d want vld=1 y=2", VLD16, Y16); end
    RDY = 1'b1; @(negedge CLK); RDY = 1'b0;
    // Edge consumed with START (before cycle 1) and one cycle after the window.
    mask = '0;
    mask[1] = 1'b1; mask[2] = 1'b1;     // A high c=-2,-1
    mask[12] = 1'b1; mask[13] = 1'b1;   // A high c=9,10
    run_win(10, 1'b0, mask, bc);
    checks++; if ({VLD16, Y16} !== {1'b1, 16'd0})
      begin errors++; $display("FAIL bnd_out_y got vld=%b y=%0d want vld=1 y=0", VLD16, Y16); end
    @(negedge CLK);
    checks++; if ({VLD16, Y16} !== {1'b1, 16'd0})
      begin errors++; $display("FAIL bnd_out_hold got vld=%b y=%0d want vld=1 y=0", VLD16, Y16); end
    RDY = 1'b1; @(negedge CLK); RDY = 1'b0;
    checks++; if (VLD16 !== 1'b0) begin errors++; $display("FAIL bnd_rdy_clear got %b want 0", VLD16); end
  endtask

  task automatic test_saturation();
    logic [255:0] mask;
    int           bc;
    mask = '0;
    for (int k = 0; k < 20; k++) begin
      mask[5 + 8*k + 3] = 1'b1;
      mask[5 + 8*k + 4] = 1'b1;
    end
    run_win(200, 1'b1, mask, bc);
    checks++; if (bc !== 200)     begin errors++; $display("FAIL sat_busy_cycles got %0d want 200", bc); end
    checks++; if (VLD4 !== 1'b1)  begin errors++; $display("FAIL sat_vld got %b want 1", VLD4); end
    checks++; if (Y4 !== 4'd15)   begin errors++; $display("FAIL sat_y got %0d want 15", Y4); end
    checks++; if (OVF4 !== 1'b1)  begin errors++; $display("FAIL sat_ovf got %b want 1", OVF4); end
    checks++; if (BUSY16 !== 1'b0) begin errors++; $display("FAIL sat_dut16_idle got %b want 0", BUSY16); end
    RDY = 1'b1; @(negedge CLK); RDY = 1'b0;
    checks++; if (VLD4 !== 1'b0)  begin errors++; $display("FAIL sat_rdy_clear got %b want 0", VLD4); end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_handshake();
    test_abort();
    test_win_zero();
    test_boundary();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_edge_monitor
`default_nettype wire

// File: doc/edge_monitor.md
EDGE_MONITOR -- requirements
Module: edge_monitor

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the window timer, edge counter and result.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth on A; legal values are 2 or 3.
REQ-003 Port CLK  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-004 Port RN  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port A  input  1  SHALL be the asynchronous monitored signal, driven by the upstream buffer cell output.
REQ-006 Port START  input  1  SHALL be a single-cycle request to begin a measurement window.
REQ-007 Port WIN  input  CNT_W  SHALL be the window length in CLK cycles, sampled when START is accepted.
REQ-008 Port RDY  input  1  SHALL be the consumer acknowledge for the result.
REQ-009 Port Y  output  CNT_W  SHALL be the rising-edge count for the completed window.
REQ-010 Port VLD  output  1  SHALL indicate that Y and OVF hold a valid result.
REQ-011 Port BUSY  output  1  SHALL be high while a window is counting.
REQ-012 Port OVF  output  1  SHALL indicate that the count saturated during the window.

Function
REQ-013 A SHALL pass through a SYNC_STAGES-flop synchronizer, followed by one history flop; a rising edge is defined as sync=1 and history=0.
REQ-014 The synchronizer and edge detector SHALL run continuously in every state.
REQ-015 A rising edge on A SHALL produce a one-cycle edge pulse SYNC_STAGES+1 cycles later, within +1 cycle for metastability.
REQ-016 The FSM SHALL have three states: IDLE, COUNT and DONE.
REQ-017 In IDLE, START=1 with WIN!=0 SHALL load timer=WIN, clear count and OVF, and enter COUNT on the next cycle.
REQ-018 In IDLE, START=1 with WIN=0 SHALL be ignored.
REQ-019 START SHALL be ignored in COUNT and DONE.
REQ-020 In COUNT, the timer SHALL decrement by 1 every cycle.
REQ-021 Each edge pulse in COUNT SHALL increment count; the window covers exactly WIN cycles, including the final one.
REQ-022 When count equals 2^CNT_W-1, a further edge SHALL leave count unchanged and set OVF (saturation, no wrap).
REQ-023 When the timer reaches 1 in COUNT, the next state SHALL be DONE.
REQ-024 On entering DONE, Y SHALL equal the final count (including any edge in the last window cycle) and VLD SHALL be 1.
REQ-025 In DONE, Y, OVF and VLD SHALL hold until RDY=1.
REQ-026 In DONE, RDY=1 SHALL clear VLD and return the FSM to IDLE in the same cycle.
REQ-027 After the return to IDLE, START SHALL be accepted on the next cycle, not the same cycle.
REQ-028 RDY SHALL have no effect outside DONE.
REQ-029 BUSY SHALL be 1 exactly in COUNT.
REQ-030 Y SHALL be registered and SHALL change only on the transition into DONE or on reset.

Reset
REQ-031 RN=0 SHALL asynchronously force IDLE, timer=0, count=0, Y=0, VLD=0, BUSY=0 and OVF=0.
REQ-032 RN=0 SHALL asynchronously clear all synchronizer and history flops.
REQ-033 Reset asserted mid-COUNT or mid-DONE SHALL abort the measurement with no result presented.
REQ-034 The first edge pulse after reset release SHALL require a 0->1 transition of the synchronized A.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (IDLE, COUNT, DONE) and default constants CNT_W_DEF=16 and SYNC_STAGES_DEF=2.
REQ-036 The synchronizer plus edge detector SHALL be one sub-module, edge_sync, with ports CLK, RN, A and EDGE.
REQ-037 The top level SHALL contain only the FSM, timer, counter and output registers.

Verification
REQ-038 Reset then idle: RN pulsed low mid-simulation -> Y=0, VLD=0, BUSY=0 and OVF=0 immediately, without waiting for CLK.
REQ-039 Basic count: WIN=100, 5 clean A pulses well inside the window -> BUSY high for 100 cycles, then VLD=1, Y=5, OVF=0.
REQ-040 Boundary edges: A edge timed so its pulse lands on window cycle 1, and another on cycle WIN -> both counted.
REQ-041 Boundary edges: a pulse landing one cycle after the window -> not counted.
REQ-042 Saturation: CNT_W=4, WIN=200, 20 A edges -> Y=15, OVF=1.
REQ-043 Handshake: RDY held low for 10 cycles in DONE -> Y stable; START pulsed in DONE -> ignored; RDY=1 -> VLD=0 next cycle; START the following cycle -> BUSY=1.
REQ-044 Abort and ignore: RN low at cycle 50 of WIN=100 -> IDLE with VLD never asserted; START with WIN=0 -> BUSY stays 0.
